// File: rtl/id_operand_read.sv
// Decode-side operand read: register file, WB bypass, per-register pending-write scoreboard
// and a single registered operand stage with valid/ready handshaking.
module id_operand_read #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [$clog2(NREGS)-1:0] id_sr1,
    input  logic [$clog2(NREGS)-1:0] id_sr2,
    input  logic                     id_use_sr1,
    input  logic                     id_use_sr2,
    input  logic [$clog2(NREGS)-1:0] id_dr,
    input  logic                     id_writes_dr,
    input  logic                     flush,
    input  logic                     wb_load_regfile,
    input  logic [$clog2(NREGS)-1:0] wbdr,
    input  logic [WIDTH-1:0]         wbdata,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [WIDTH-1:0]         op_sr1_data,
    output logic [WIDTH-1:0]         op_sr2_data,
    output logic [$clog2(NREGS)-1:0] op_dr,
    output logic                     sb_err
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    logic [WIDTH-1:0]  regs_q    [NREGS];
    logic [PEND_W-1:0] pending_q [NREGS];
    logic [PEND_W-1:0] eff       [NREGS];
    logic [NREGS-1:0]  wb_dec;
    logic [NREGS-1:0]  pend_inc;

    logic             op_valid_q;
    logic [WIDTH-1:0] op_sr1_q;
    logic [WIDTH-1:0] op_sr2_q;
    logic [IDX_W-1:0] op_dr_q;
    logic             sb_err_q;

    logic [WIDTH-1:0] sr1_val;
    logic [WIDTH-1:0] sr2_val;
    logic             hazard;
    logic             saturation;
    logic             stage_free;
    logic             fire;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wb_dec[r] = wb_load_regfile && (wbdr == IDX_W'(r)) && (pending_q[r] != '0);
            eff[r]    = pending_q[r] - PEND_W'(wb_dec[r]);
        end

        sr1_val = (wb_load_regfile && wbdr == id_sr1) ? wbdata : regs_q[id_sr1];
        sr2_val = (wb_load_regfile && wbdr == id_sr2) ? wbdata : regs_q[id_sr2];

        hazard     = (id_use_sr1 && eff[id_sr1] != '0) || (id_use_sr2 && eff[id_sr2] != '0);
        // A counter at its max can only accept a new writer if WB retires one this cycle
        saturation = id_writes_dr && (&pending_q[id_dr]) && !wb_dec[id_dr];
        stage_free = !op_valid_q || op_ready;
        id_ready   = stage_free && !hazard && !saturation && !flush;
        fire       = id_valid && id_ready;

        for (int r = 0; r < NREGS; r++) begin
            pend_inc[r] = fire && id_writes_dr && (id_dr == IDX_W'(r));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r]    <= '0;
                pending_q[r] <= '0;
            end
            op_valid_q <= 1'b0;
            op_sr1_q   <= '0;
            op_sr2_q   <= '0;
            op_dr_q    <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            if (wb_load_regfile) begin
                regs_q[wbdr] <= wbdata;
                if (pending_q[wbdr] == '0) begin
                    sb_err_q <= 1'b1;
                end
            end

            for (int r = 0; r < NREGS; r++) begin
                if (flush) begin
                    pending_q[r] <= '0;
                end else if (pend_inc[r] && !wb_dec[r]) begin
                    pending_q[r] <= pending_q[r] + 1'b1;
                end else if (wb_dec[r] && !pend_inc[r]) begin
                    pending_q[r] <= pending_q[r] - 1'b1;
                end
            end

            if (flush) begin
                op_valid_q <= 1'b0;
            end else if (fire) begin
                op_valid_q <= 1'b1;
                op_sr1_q   <= sr1_val;
                op_sr2_q   <= sr2_val;
                op_dr_q    <= id_dr;
            end else if (op_ready) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    assign op_valid    = op_valid_q;
    assign op_sr1_data = op_sr1_q;
    assign op_sr2_data = op_sr2_q;
    assign op_dr       = op_dr_q;
    assign sb_err      = sb_err_q;

endmodule
